mips_exec_datapath: RTL and testbench

Execute-stage datapath for the multicycle MIPS bus CPU. It combines three parts: a 32×32 register file, an ALU-control decoder that maps opcode and funct to an ALU function code, and a combinational 32-bit ALU. The CPU FSM drives register addresses, the write enable, write data, opcode/funct/shamt and the B-operand select. It consumes the operand values, the ALU result and the `register_v0` debug output.

---
 rtl/mips_pkg.sv | 33 +++
 rtl/alu.sv | 31 +++
 rtl/alu_ctrl.sv | 21 ++
 rtl/reg_file.sv | 26 ++
 rtl/mips_exec_datapath.sv | 32 +++
 tb/tb_mips_exec_datapath.sv | 165 ++++++++++++++++
 6 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: opcode and ALU function encodings shared by the execute datapath and CPU FSM
package mips_pkg;
  typedef enum logic [5:0] {
    OP_RTYPE = 6'b000000,
    OP_J     = 6'b000010,
    OP_JAL   = 6'b000011,
    OP_ADDIU = 6'b001001,
    OP_SLTI  = 6'b001010,
    OP_SLTIU = 6'b001011,
    OP_ANDI  = 6'b001100,
    OP_ORI   = 6'b001101,
    OP_XORI  = 6'b001110,
    OP_LW    = 6'b100011,
    OP_SW    = 6'b101011
  } opcode_t;
  typedef enum logic [5:0] {
    FN_SLL  = 6'b000000,
    FN_SRL  = 6'b000010,
    FN_SRA  = 6'b000011,
    FN_SLLV = 6'b000100,
    FN_SRLV = 6'b000110,
    FN_SRAV = 6'b000111,
    FN_JR   = 6'b001000,
    FN_ADDU = 6'b100001,
    FN_SUBU = 6'b100011,
    FN_AND  = 6'b100100,
    FN_OR   = 6'b100101,
    FN_XOR  = 6'b100110,
    FN_NOR  = 6'b100111,
    FN_SLT  = 6'b101010,
    FN_SLTU = 6'b101011
  } fn_t;
endpackage

// File: rtl/alu.sv
// alu: combinational 32-bit ALU; undefined function codes produce zero
module alu
  import mips_pkg::*;
(
  input  logic [5:0]  fncode,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [4:0]  shamt,
  output logic [31:0] result
);
  always_comb begin
    result = 32'd0;
    case (fncode)
      FN_ADDU: result = op_a + op_b;
      FN_SUBU: result = op_a - op_b;
      FN_AND:  result = op_a & op_b;
      FN_OR:   result = op_a | op_b;
      FN_XOR:  result = op_a ^ op_b;
      FN_NOR:  result = ~(op_a | op_b);
      FN_SLT:  result = {31'd0, $signed(op_a) < $signed(op_b)};
      FN_SLTU: result = {31'd0, op_a < op_b};
      FN_SLL:  result = op_b << shamt;
      FN_SRL:  result = op_b >> shamt;
      FN_SRA:  result = $signed(op_b) >>> shamt;
      FN_SLLV: result = op_b << op_a[4:0];
      FN_SRLV: result = op_b >> op_a[4:0];
      FN_SRAV: result = $signed(op_b) >>> op_a[4:0];
      default: result = 32'd0;
    endcase
  end
endmodule

// File: rtl/alu_ctrl.sv
// alu_ctrl: maps opcode/funct to the ALU function code (MIPS funct encoding)
module alu_ctrl
  import mips_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] rtype_fncode,
  output logic [5:0] fncode
);
  always_comb begin
    fncode = FN_ADDU;
    case (opcode)
      OP_RTYPE: fncode = rtype_fncode;
      OP_ANDI:  fncode = FN_AND;
      OP_ORI:   fncode = FN_OR;
      OP_XORI:  fncode = FN_XOR;
      OP_SLTI:  fncode = FN_SLT;
      OP_SLTIU: fncode = FN_SLTU;
      default:  fncode = FN_ADDU;
    endcase
  end
endmodule

// File: rtl/reg_file.sv
// reg_file: 32x32 register file, two combinational read ports plus a v0 tap, r0 hardwired to zero
module reg_file (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  addr_a,
  input  logic [4:0]  addr_b,
  input  logic [4:0]  write_addr,
  input  logic        write,
  input  logic [31:0] data_in,
  output logic [31:0] a,
  output logic [31:0] b,
  output logic [31:0] register_v0
);
  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];
  always_comb begin
    regs_d = regs_q;
    if (reset) regs_d = '{default: '0};
    else if (write && write_addr != 5'd0) regs_d[write_addr] = data_in;
  end
  always_ff @(posedge clk) regs_q <= regs_d;
  // r0 is masked on read so it is zero even before the first reset
  assign a = (addr_a == 5'd0) ? 32'd0 : regs_q[addr_a];
  assign b = (addr_b == 5'd0) ? 32'd0 : regs_q[addr_b];
  assign register_v0 = regs_q[2];
endmodule

// File: rtl/mips_exec_datapath.sv
// mips_exec_datapath: register file, ALU-control decoder and ALU with the B-operand mux
module mips_exec_datapath
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  addr_a,
  input  logic [4:0]  addr_b,
  input  logic [4:0]  write_addr,
  input  logic        write,
  input  logic [31:0] data_in,
  input  logic [5:0]  opcode,
  input  logic [5:0]  rtype_fncode,
  input  logic [4:0]  shamt,
  input  logic        alu_b_sel,
  input  logic [31:0] imm,
  output logic [31:0] a,
  output logic [31:0] b,
  output logic [5:0]  fncode,
  output logic [31:0] alu_out,
  output logic [31:0] register_v0
);
  logic [31:0] alu_b;
  reg_file u_reg_file (
    .clk(clk), .reset(reset), .addr_a(addr_a), .addr_b(addr_b),
    .write_addr(write_addr), .write(write), .data_in(data_in),
    .a(a), .b(b), .register_v0(register_v0)
  );
  alu_ctrl u_alu_ctrl (.opcode(opcode), .rtype_fncode(rtype_fncode), .fncode(fncode));
  assign alu_b = alu_b_sel ? imm : b;
  alu u_alu (.fncode(fncode), .op_a(a), .op_b(alu_b), .shamt(shamt), .result(alu_out));
endmodule

// File: tb/tb_mips_exec_datapath.sv
// tb_mips_exec_datapath: directed plus random stimulus, scoreboard checked against a behavioural model
module tb_mips_exec_datapath;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [4:0]  addr_a = '0, addr_b = '0, write_addr = '0, shamt = '0;
  logic        write = 1'b0, alu_b_sel = 1'b0;
  logic [31:0] data_in = '0, imm = '0;
  logic [5:0]  opcode = '0, rtype_fncode = '0;
  logic [31:0] a, b, alu_out, register_v0;
  logic [5:0]  fncode;

  mips_exec_datapath dut (
    .clk(clk), .reset(reset), .addr_a(addr_a), .addr_b(addr_b),
    .write_addr(write_addr), .write(write), .data_in(data_in),
    .opcode(opcode), .rtype_fncode(rtype_fncode), .shamt(shamt),
    .alu_b_sel(alu_b_sel), .imm(imm), .a(a), .b(b), .fncode(fncode),
    .alu_out(alu_out), .register_v0(register_v0)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          chk;
    logic [31:0] a, b, v0, alu;
    logic [5:0]  fn;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m [32];
  bit          known = 1'b0;
  int          n_chk = 0, n_fail = 0;

  function automatic logic [5:0] ref_fn(logic [5:0] op, logic [5:0] f);
    case (op)
      6'o00: return f;
      6'o14: return 6'h24;
      6'o15: return 6'h25;
      6'o16: return 6'h26;
      6'o12: return 6'h2a;
      6'o13: return 6'h2b;
      default: return 6'h21;
    endcase
  endfunction

  function automatic logic [31:0] ref_alu(logic [5:0] f, logic [31:0] x, logic [31:0] y, logic [4:0] s);
    longint sx = longint'($signed(x));
    longint sy = longint'($signed(y));
    longint ux = longint'(x);
    longint uy = longint'(y);
    int     v = int'(x[4:0]);
    case (f)
      6'h21: return 32'((ux + uy) % (64'd1 << 32));
      6'h23: return 32'((ux - uy + (64'd1 << 32)) % (64'd1 << 32));
      6'h24: return x & y;
      6'h25: return x | y;
      6'h26: return x ^ y;
      6'h27: return ~(x | y);
      6'h2a: return (sx < sy) ? 32'd1 : 32'd0;
      6'h2b: return (ux < uy) ? 32'd1 : 32'd0;
      6'h00: return 32'(uy * (64'd1 << s));
      6'h02: return 32'(uy / (64'd1 << s));
      6'h03: return 32'(sy >>> s);
      6'h04: return 32'(uy * (64'd1 << v));
      6'h06: return 32'(uy / (64'd1 << v));
      6'h07: return 32'(sy >>> v);
      default: return 32'd0;
    endcase
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      if (e.chk) begin
        check("a", a, e.a);
        check("b", b, e.b);
        check("register_v0", register_v0, e.v0);
        check("fncode", {26'd0, fncode}, {26'd0, e.fn});
        check("alu_out", alu_out, e.alu);
      end
    end
  end

  task automatic step(bit rst, bit wr, logic [4:0] wa, logic [31:0] din, logic [4:0] aa, logic [4:0] ab,
                      logic [5:0] op, logic [5:0] fn, logic [4:0] sh, bit bsel, logic [31:0] im);
    exp_t e;
    logic [31:0] ea, eb;
    reset = rst; write = wr; write_addr = wa; data_in = din; addr_a = aa; addr_b = ab;
    opcode = op; rtype_fncode = fn; shamt = sh; alu_b_sel = bsel; imm = im;
    ea = (aa == 0) ? 32'd0 : m[aa];
    eb = (ab == 0) ? 32'd0 : m[ab];
    e.chk = known;
    e.a = ea;
    e.b = eb;
    e.v0 = m[2];
    e.fn = ref_fn(op, fn);
    e.alu = ref_alu(e.fn, ea, bsel ? im : eb, sh);
    sb.push_back(e);
    @(posedge clk);
    if (rst) begin
      foreach (m[i]) m[i] = 32'd0;
      known = 1'b1;
    end else if (wr && wa != 0) m[wa] = din;
    #1;
  endtask

  task automatic wr_reg(logic [4:0] r, logic [31:0] v);
    step(0, 1, r, v, 0, 0, 6'o00, 6'h21, 0, 0, 0);
  endtask

  initial begin
    @(posedge clk);
    #1;
    step(1, 0, 0, 0, 0, 0, 6'o00, 6'h21, 0, 0, 0);
    step(0, 1, 0, 32'hDEADBEEF, 0, 0, 6'o00, 6'h21, 0, 0, 0);
    step(0, 0, 0, 0, 0, 2, 6'o00, 6'h21, 0, 0, 0);
    step(0, 1, 2, 32'h12345678, 0, 2, 6'o00, 6'h21, 0, 0, 0);
    step(0, 0, 0, 0, 0, 2, 6'o00, 6'h21, 0, 0, 0);
    wr_reg(1, 32'hFFFFFFFF);
    wr_reg(3, 32'd2);
    step(0, 0, 0, 0, 1, 3, 6'o00, 6'h21, 0, 0, 0);
    step(0, 0, 0, 0, 3, 1, 6'o00, 6'h23, 0, 0, 0);
    wr_reg(1, 32'd5);
    step(0, 0, 0, 0, 1, 0, 6'o11, 6'h00, 0, 1, 32'hFFFFFFFD);
    step(0, 0, 0, 0, 1, 0, 6'o43, 6'h3f, 0, 1, 32'hFFFFFFFD);
    step(0, 0, 0, 0, 1, 0, 6'o53, 6'h08, 0, 1, 32'hFFFFFFFD);
    wr_reg(6, 32'hFFFFFFFF);
    wr_reg(5, 32'd1);
    step(0, 0, 0, 0, 6, 5, 6'o00, 6'h2a, 0, 0, 0);
    step(0, 0, 0, 0, 6, 5, 6'o00, 6'h2b, 0, 0, 0);
    wr_reg(7, 32'h80000000);
    wr_reg(8, 32'h21);
    wr_reg(9, 32'd1);
    step(0, 0, 0, 0, 0, 7, 6'o00, 6'h02, 4, 0, 0);
    step(0, 0, 0, 0, 0, 7, 6'o00, 6'h03, 4, 0, 0);
    step(0, 0, 0, 0, 8, 9, 6'o00, 6'h04, 0, 0, 0);
    step(0, 0, 0, 0, 8, 9, 6'o00, 6'h08, 0, 0, 0);
    step(1, 1, 4, 32'hCAFEF00D, 4, 2, 6'o00, 6'h21, 0, 0, 0);
    step(0, 0, 0, 0, 4, 2, 6'o00, 6'h21, 0, 0, 0);
    for (int i = 0; i < 600; i++) begin
      logic [5:0] op;
      logic [5:0] fn;
      op = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'o00;
      fn = 6'($urandom);
      step($urandom_range(0, 59) == 0, $urandom_range(0, 1) == 1, 5'($urandom), $urandom,
           5'($urandom), 5'($urandom), op, fn, 5'($urandom), $urandom_range(0, 1) == 1, $urandom);
    end
    repeat (3) @(negedge clk);
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
